// File: rtl/imem_loader.sv
// Instruction-memory loader: streams 16-bit host words into consecutive
// instruction-memory addresses and holds the fetch stage in reset meanwhile.
// A single registered write port is driven one cycle after each accepted word.
// The loader reports completion, rejection and a running checksum.

module imem_loader #(
    parameter int unsigned ADDR_W          = 10,
    parameter int unsigned RESERVED_BASE   = 32,
    parameter bit          PROTECT_VECTORS = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [ADDR_W:0]   load_count,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [15:0]       in_data,
    output logic              in_ready,
    output logic              mem_write_enable,
    output logic [ADDR_W-1:0] mem_write_address,
    output logic [15:0]       mem_write_data,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       checksum
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    // Range arithmetic is carried in ADDR_W+2 bits so base+count cannot overflow.
    localparam logic [ADDR_W+1:0] DepthExt   = (ADDR_W + 2)'(DEPTH);
    localparam logic [ADDR_W+1:0] ResBaseExt = (ADDR_W + 2)'(RESERVED_BASE);
    localparam logic [ADDR_W-1:0] AddrOne    = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CntOne     = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StLoad,
        StFlush,
        StDone,
        StErr
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] cur_q;
    logic [ADDR_W:0]   remaining_q;
    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [15:0]       wdata_q;
    logic              hold_q;
    logic              busy_q;
    logic              done_q;
    logic              error_q;
    logic [15:0]       checksum_q;

    logic [ADDR_W+1:0] end_ext;
    logic              range_bad;
    logic              vector_bad;
    logic              handshake;

    // Range test on the latched base (cur_q) and count (remaining_q) while in CHECK.
    always_comb begin
        end_ext    = {2'b00, cur_q} + {1'b0, remaining_q};
        range_bad  = end_ext > DepthExt;
        vector_bad = PROTECT_VECTORS && (remaining_q != '0) && ({2'b00, cur_q} < ResBaseExt);
        // Abort wins over a same-cycle valid word, so it also withdraws ready.
        in_ready   = (state_q == StLoad) && !abort;
        handshake  = in_ready && in_valid;
    end

    // Loader FSM; every output except in_ready is a flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cur_q       <= '0;
            remaining_q <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            hold_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            checksum_q  <= '0;
        end else begin
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (load_start) begin
                        cur_q       <= load_base;
                        remaining_q <= load_count;
                        checksum_q  <= '0;
                        hold_q      <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= StCheck;
                    end
                end
                StCheck: begin
                    if (range_bad || vector_bad) begin
                        error_q <= 1'b1;
                        state_q <= StErr;
                    end else if (remaining_q == '0) begin
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    if (abort) begin
                        // Words already written stay; no done/error pulse.
                        hold_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else if (handshake) begin
                        we_q        <= 1'b1;
                        waddr_q     <= cur_q;
                        wdata_q     <= in_data;
                        cur_q       <= cur_q + AddrOne;
                        remaining_q <= remaining_q - CntOne;
                        checksum_q  <= checksum_q + in_data;
                        if (remaining_q == CntOne) begin
                            state_q <= StFlush;
                        end
                    end
                end
                StFlush: begin
                    done_q  <= 1'b1;
                    state_q <= StDone;
                end
                StDone, StErr: begin
                    hold_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    hold_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign mem_write_enable  = we_q;
    assign mem_write_address = waddr_q;
    assign mem_write_data    = wdata_q;
    assign cpu_hold          = hold_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign error             = error_q;
    assign checksum          = checksum_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomised bench for imem_loader. Each load is planned up front from the
// input schedule: which cycles accept a word, where each word must land,
// and the cycle of done/error/abort. The DUT is then checked cycle by cycle.

module tb_imem_loader;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;
    localparam int RES    = 32;
    localparam int MAXC   = 256;

    logic              clk = 1'b0;
    logic              reset;
    logic              load_start;
    logic [ADDR_W-1:0] load_base;
    logic [ADDR_W:0]   load_count;
    logic              abort;
    logic              in_valid;
    logic [15:0]       in_data;
    logic              in_ready;
    logic              mem_write_enable;
    logic [ADDR_W-1:0] mem_write_address;
    logic [15:0]       mem_write_data;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              error;
    logic [15:0]       checksum;

    imem_loader #(
        .ADDR_W         (ADDR_W),
        .RESERVED_BASE  (RES),
        .PROTECT_VECTORS(1'b1)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .load_start       (load_start),
        .load_base        (load_base),
        .load_count       (load_count),
        .abort            (abort),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_ready         (in_ready),
        .mem_write_enable (mem_write_enable),
        .mem_write_address(mem_write_address),
        .mem_write_data   (mem_write_data),
        .cpu_hold         (cpu_hold),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .checksum         (checksum)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Per-cycle stimulus schedule, cycle 0 = load_start cycle.
    bit          sv[MAXC];
    logic [15:0] sd[MAXC];
    bit          sa[MAXC];
    bit          sl[MAXC];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic fill_sched(input int vprob, input int abort_c, input bit stray_starts);
        for (int c = 0; c < MAXC; c++) begin
            sv[c] = (c >= 150) ? 1'b1 : ($urandom_range(0, 99) < vprob);
            sd[c] = 16'($urandom);
            sa[c] = (c == abort_c);
            sl[c] = stray_starts && ($urandom_range(0, 9) == 0);
        end
    endtask

    task automatic run_txn(input string name, input int base, input int count);
        bit          hs[MAXC];
        bit          bad;
        bit          has_load;
        int          end_c;
        int          done_c;
        int          err_c;
        int          load_hi;
        int          acc;
        int          k;
        logic [15:0] sum;
        bit          exp_we;

        // Plan the whole load from the schedule.
        for (int c = 0; c < MAXC; c++) hs[c] = 1'b0;
        bad      = (base + count > DEPTH) || (count != 0 && base < RES);
        has_load = 1'b0;
        done_c   = -1;
        err_c    = -1;
        load_hi  = -1;
        acc      = 0;
        sum      = '0;
        end_c    = 2;
        if (bad) begin
            err_c = 2;
        end else if (count == 0) begin
            done_c = 2;
        end else begin
            has_load = 1'b1;
            for (int c = 2; c < MAXC - 4; c++) begin
                if (sa[c]) begin
                    end_c   = c;
                    load_hi = c;
                    break;
                end
                if (sv[c]) begin
                    hs[c] = 1'b1;
                    sum   = sum + sd[c];
                    acc++;
                    if (acc == count) begin
                        load_hi = c;
                        done_c  = c + 2;
                        end_c   = c + 2;
                        break;
                    end
                end
            end
        end

        k = 0;
        for (int c = 0; c <= end_c + 1; c++) begin
            @(negedge clk);
            exp_we = 1'b0;
            if (c >= 1) exp_we = hs[c-1];
            check({name, ".we"}, 32'(mem_write_enable), 32'(exp_we));
            if (exp_we) begin
                check({name, ".addr"}, 32'(mem_write_address), 32'(base + k));
                check({name, ".data"}, 32'(mem_write_data), 32'(sd[c-1]));
                k++;
            end
            check({name, ".done"}, 32'(done), 32'(c == done_c));
            check({name, ".error"}, 32'(error), 32'(c == err_c));
            check({name, ".hold"}, 32'(cpu_hold), 32'(c >= 1 && c <= end_c));
            check({name, ".busy"}, 32'(busy), 32'(c >= 1 && c <= end_c));
            if (c == end_c + 1) check({name, ".sum"}, 32'(checksum), 32'(sum));

            load_start = (c == 0) || (c >= 1 && c <= end_c && sl[c]);
            load_base  = ADDR_W'(base);
            load_count = (ADDR_W + 1)'(count);
            in_valid   = sv[c];
            in_data    = sd[c];
            abort      = sa[c];
            #1;
            check({name, ".ready"}, 32'(in_ready),
                  32'(has_load && c >= 2 && c <= load_hi && !sa[c]));
        end
        load_start = 1'b0;
        abort      = 1'b0;
        in_valid   = 1'b0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int base;
        int count;
        int abort_c;
        reset      = 1'b0;
        load_start = 1'b0;
        load_base  = '0;
        load_count = '0;
        abort      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        repeat (2) @(negedge clk);
        check("rst.we", 32'(mem_write_enable), 0);
        check("rst.hold", 32'(cpu_hold), 0);
        check("rst.busy", 32'(busy), 0);
        check("rst.done", 32'(done), 0);
        check("rst.error", 32'(error), 0);
        check("rst.sum", 32'(checksum), 0);
        check("rst.ready", 32'(in_ready), 0);
        reset = 1'b1;
        @(negedge clk);

        // Basic load.
        fill_sched(100, -1, 1'b0);
        sd[2] = 16'h4000;
        sd[3] = 16'h1234;
        sd[4] = 16'hFFFF;
        run_txn("basic", 32, 3);
        check("basic.sum_const", 32'(checksum), 32'h5233);

        // Backpressure: valid 1,0,0,1.
        fill_sched(100, -1, 1'b0);
        sv[3] = 1'b0;
        sv[4] = 1'b0;
        run_txn("bp", 40, 2);

        // Range boundaries.
        fill_sched(100, -1, 1'b0);
        run_txn("rng_hi", 1020, 5);
        run_txn("rng_vec", 0, 1);
        run_txn("rng_ok", 1019, 5);
        run_txn("rng_full", 0, 1024);
        run_txn("rng_edge", 31, 1);

        // Zero count.
        run_txn("zero", 100, 0);
        check("zero.sum_const", 32'(checksum), 0);

        // Abort with the third valid word.
        fill_sched(100, 4, 1'b0);
        run_txn("abort", 64, 4);

        // Reset after one handshake, while its write is on the port.
        fill_sched(100, -1, 1'b0);
        @(negedge clk);
        load_start = 1'b1;
        load_base  = 10'd40;
        load_count = 11'd3;
        in_valid   = 1'b1;
        in_data    = 16'hABCD;
        @(negedge clk);
        load_start = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("mid_rst.we", 32'(mem_write_enable), 0);
        check("mid_rst.hold", 32'(cpu_hold), 0);
        check("mid_rst.busy", 32'(busy), 0);
        check("mid_rst.sum", 32'(checksum), 0);
        check("mid_rst.ready", 32'(in_ready), 0);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        fill_sched(100, -1, 1'b0);
        run_txn("after_rst", 200, 3);

        // Random loads.
        for (int t = 0; t < 40; t++) begin
            count = $urandom_range(0, 12);
            case ($urandom_range(0, 3))
                0:       base = $urandom_range(0, 40);
                1:       base = $urandom_range(1005, 1023);
                default: base = $urandom_range(32, 1000);
            endcase
            abort_c = -1;
            if (count > 0 && $urandom_range(0, 3) == 0) abort_c = 2 + $urandom_range(0, count - 1);
            fill_sched($urandom_range(30, 100), abort_c, 1'b1);
            run_txn("rand", base, count);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
